// File: rtl/top2_classifier.sv
// top2_classifier: sequential scan of a score vector that reports the two largest elements, their margin and a confidence flag.
module top2_classifier #(
  parameter int VEC_SIZE    = 107,
  parameter int DATA_WIDTH  = 16,
  parameter int FIXED_PNT   = 8,
  parameter int CONF_THRESH = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] vec_in [VEC_SIZE],
  output logic                         data_ready,
  output logic [$clog2(VEC_SIZE):0]    class_idx,
  output logic signed [DATA_WIDTH-1:0] class_val,
  output logic [$clog2(VEC_SIZE):0]    second_idx,
  output logic signed [DATA_WIDTH-1:0] second_val,
  output logic [DATA_WIDTH-1:0]        margin,
  output logic                         confident
);
  localparam int IW = $clog2(VEC_SIZE) + 1;
  localparam logic signed [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAXM = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] THR = DATA_WIDTH'(CONF_THRESH);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] idx, best_idx, sec_idx, nb_idx, ns_idx;
  logic signed [DATA_WIDTH-1:0] v, best_val, sec_val, nb_val, ns_val;
  logic [DATA_WIDTH:0] diff;
  logic first, second, gt_b, gt_s, last;
  always_comb begin
    v = vec_in[0];
    for (int i = 0; i < VEC_SIZE; i++) v = (idx == IW'(i)) ? vec_in[i] : v;
  end
  assign first  = idx == '0;
  assign second = idx == IW'(1);
  assign last   = idx == IW'(VEC_SIZE - 1);
  assign gt_b   = v > best_val;
  assign gt_s   = v > sec_val;
  // element 1 always seeds second (unless it displaces best) so second_idx names a real element
  assign nb_val = (first || gt_b) ? v : best_val;
  assign nb_idx = (first || gt_b) ? idx : best_idx;
  assign ns_val = first ? MINV : gt_b ? best_val : (second || gt_s) ? v : sec_val;
  assign ns_idx = first ? '0 : gt_b ? best_idx : (second || gt_s) ? idx : sec_idx;
  assign diff   = {nb_val[DATA_WIDTH-1], nb_val} - {ns_val[DATA_WIDTH-1], ns_val};
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (enable ? SCAN : IDLE) :
          state == SCAN ? (!enable ? IDLE : last ? DONE : SCAN) :
          (enable ? DONE : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      sec_val    <= '0;
      sec_idx    <= '0;
      data_ready <= 1'b0;
      class_idx  <= '0;
      class_val  <= '0;
      second_idx <= '0;
      second_val <= '0;
      margin     <= '0;
      confident  <= 1'b0;
    end else begin
      idx        <= state == SCAN ? idx + 1'b1 : '0;
      data_ready <= nxt == DONE;
      if (state == SCAN) begin
        best_val <= nb_val;
        best_idx <= nb_idx;
        sec_val  <= ns_val;
        sec_idx  <= ns_idx;
      end
      if (state == SCAN && nxt == DONE) begin
        class_idx  <= nb_idx;
        class_val  <= nb_val;
        second_idx <= ns_idx;
        second_val <= ns_val;
        margin     <= (diff[DATA_WIDTH] || diff[DATA_WIDTH-1]) ? MAXM : diff[DATA_WIDTH-1:0];
        confident  <= nb_val >= THR;
      end
    end
  end
endmodule

// File: tb/tb_top2_classifier.sv
// tb_top2_classifier: directed and random vectors checked against a sort-style top-two reference model.
module tb_top2_classifier;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = $clog2(N) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic signed [DW-1:0] vec_in [N];
  logic data_ready, confident;
  logic [IW-1:0] class_idx, second_idx;
  logic signed [DW-1:0] class_val, second_val;
  logic [DW-1:0] margin;
  int tests = 0;
  int fails = 0;
  int e_ci, e_cv, e_si, e_sv, e_m, e_cf;

  top2_classifier #(.VEC_SIZE(N), .DATA_WIDTH(DW), .FIXED_PNT(8), .CONF_THRESH(128)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vec_in(vec_in),
    .data_ready(data_ready), .class_idx(class_idx), .class_val(class_val),
    .second_idx(second_idx), .second_val(second_val), .margin(margin), .confident(confident)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d);
    vec_in[0] = DW'(a);
    vec_in[1] = DW'(b);
    vec_in[2] = DW'(c);
    vec_in[3] = DW'(d);
  endtask

  // largest value with lowest index, then largest of the rest with lowest index
  task automatic model();
    int vals[N];
    bit found = 0;
    for (int i = 0; i < N; i++) vals[i] = int'(vec_in[i]);
    e_ci = 0;
    for (int i = 1; i < N; i++) if (vals[i] > vals[e_ci]) e_ci = i;
    e_cv = vals[e_ci];
    e_si = 0;
    e_sv = -32768;
    for (int i = 0; i < N; i++)
      if (i != e_ci && (!found || vals[i] > e_sv)) begin
        e_sv = vals[i];
        e_si = i;
        found = 1;
      end
    e_m  = (e_cv - e_sv > 32767) ? 32767 : e_cv - e_sv;
    e_cf = e_cv >= 128 ? 1 : 0;
  endtask

  task automatic check_results(input string tag);
    check({tag, ".class_idx"}, int'(class_idx), e_ci);
    check({tag, ".class_val"}, int'(class_val), e_cv);
    check({tag, ".second_idx"}, int'(second_idx), e_si);
    check({tag, ".second_val"}, int'(second_val), e_sv);
    check({tag, ".margin"}, int'(margin), e_m);
    check({tag, ".confident"}, int'(confident), e_cf);
  endtask

  task automatic scan(input string tag, input bit drop);
    int n = 0;
    model();
    enable = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!data_ready && n < 20);
    check({tag, ".latency"}, n, N + 1);
    check_results(tag);
    if (drop) begin
      enable = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ".ready_clear"}, int'(data_ready), 0);
      check_results({tag, ".held"});
    end
  endtask

  initial begin
    set_vec(0, 0, 0, 0);
    #1;
    check("reset.ready", int'(data_ready), 0);
    check("reset.class_idx", int'(class_idx), 0);
    check("reset.margin", int'(margin), 0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_vec(20, 200, 30, 6);
    scan("peak", 1);
    check("peak.margin_const", int'(margin), 170);
    set_vec(64, 64, 64, 64);
    scan("ties", 1);
    set_vec(10, 50, 90, 100);
    scan("ascend", 1);
    set_vec(32767, -32768, -32768, -32768);
    scan("saturate", 1);
    check("saturate.second_idx_const", int'(second_idx), 1);
    set_vec(-5, 300, 128, -7);
    enable = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort.ready", int'(data_ready), 0);
    end
    check_results("abort.held");
    scan("reenable", 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("done_hold.ready", int'(data_ready), 1);
    check_results("done_hold");
    rst_n = 1'b0;
    #1;
    e_ci = 0; e_cv = 0; e_si = 0; e_sv = 0; e_m = 0; e_cf = 0;
    check("rst_done.ready", int'(data_ready), 0);
    check_results("rst_done");
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_vec(-100, -20, -300, -20);
    scan("after_rst", 1);
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        int v;
        int mode = $urandom_range(0, 2);
        int pick = $urandom_range(0, 3);
        v = mode == 0 ? $urandom_range(0, 6) - 3 :
            mode == 1 ? int'($urandom_range(0, 65535)) - 32768 :
            pick == 0 ? -32768 : pick == 1 ? 32767 : pick == 2 ? 128 : 127;
        vec_in[i] = DW'(v);
      end
      scan($sformatf("rand%0d", t), 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
